// File: rtl/sic4_ctrl_fsm.sv
// SIC-4 multi-cycle control unit: fetch/decode/exec/mem/wb sequencing, memory watchdog, halt.
// Latency: R/ADDI 4, LW 5, SW 4, BEQ 3 cycles with zero-wait memory (FETCH ack in first cycle).
// Backpressure: FETCH/MEM hold mem_req until mem_ack; TIMEOUT cycles without ack traps in ERR.
// Optional macro SIC4_CTRL_RETIRE_CNT_EN adds the o_retired instruction counter.
module sic4_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_rtd,
  input  logic [1:0]  i_rs,
  input  logic [1:0]  i_fun_imm,
  input  logic        i_alu_zero,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_addr_sel,
  output logic        o_ir_load,
  output logic        o_pc_inc,
  output logic        o_pc_branch,
  output logic [1:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_reg_we,
  output logic        o_wb_sel,
  output logic        o_halted,
  output logic        o_bus_err,
  output logic [2:0]  o_state
`ifdef SIC4_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0] o_retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_MEM  = 2'b10;

  // Watchdog fires on the cycle that would make the no-ack count reach TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [TO_W-1:0] r_wdog;

  logic       w_is_halt;
  logic       w_mem_phase;
  logic       w_wdog_hit;
  logic [1:0] w_isa_alu_op;
  logic       w_isa_alu_src;

  assign w_is_halt   = ({i_op, i_rtd, i_rs, i_fun_imm} == 8'hFF);
  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wdog_hit  = (r_wdog == TO_LAST);

  // ALU control from the latched instruction fields.
  always_comb begin
    w_isa_alu_op  = 2'b00;
    w_isa_alu_src = 1'b0;
    case (i_op)
      OP_R:    begin w_isa_alu_op = i_fun_imm; w_isa_alu_src = 1'b0; end
      OP_ADDI: begin w_isa_alu_op = 2'b00;     w_isa_alu_src = 1'b1; end
      OP_MEM:  begin w_isa_alu_op = 2'b00;     w_isa_alu_src = 1'b1; end
      default: begin w_isa_alu_op = 2'b01;     w_isa_alu_src = 1'b0; end
    endcase
  end

  // State sequencing and memory watchdog; any ack or state change clears the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_wdog  <= '0;
    end else begin
      if (w_mem_phase && !i_mem_ack && !w_wdog_hit) begin
        r_wdog <= r_wdog + TO_W'(1);
      end else begin
        r_wdog <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_mem_ack)       r_state <= S_DECODE;
          else if (w_wdog_hit) r_state <= S_ERR;
        end
        S_DECODE: begin
          r_state <= w_is_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          case (i_op)
            OP_R, OP_ADDI: r_state <= S_WB;
            OP_MEM:        r_state <= S_MEM;
            default:       r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (i_mem_ack)       r_state <= i_fun_imm[0] ? S_FETCH : S_WB;
          else if (w_wdog_hit) r_state <= S_ERR;
        end
        S_WB: begin
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_ERR;
        end
      endcase
    end
  end

  // Outputs decoded from the state register; ir_load/pc_inc follow ack within the FETCH cycle.
  // ALU controls stay valid through MEM and WB since the address and write-back data come
  // straight from the combinational ALU.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_addr_sel  = 1'b0;
    o_ir_load   = 1'b0;
    o_pc_inc    = 1'b0;
    o_pc_branch = 1'b0;
    o_alu_op    = 2'b00;
    o_alu_src   = 1'b0;
    o_reg_we    = 1'b0;
    o_wb_sel    = 1'b0;
    o_halted    = 1'b0;
    o_bus_err   = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        o_ir_load = i_mem_ack;
        o_pc_inc  = i_mem_ack;
      end
      S_EXEC: begin
        o_alu_op    = w_isa_alu_op;
        o_alu_src   = w_isa_alu_src;
        o_pc_branch = (i_op == 2'b11) && i_alu_zero;
      end
      S_MEM: begin
        o_mem_req  = 1'b1;
        o_addr_sel = 1'b1;
        o_mem_we   = i_fun_imm[0];
        o_alu_op   = w_isa_alu_op;
        o_alu_src  = w_isa_alu_src;
      end
      S_WB: begin
        o_reg_we  = 1'b1;
        o_wb_sel  = (i_op == OP_MEM);
        o_alu_op  = w_isa_alu_op;
        o_alu_src = w_isa_alu_src;
      end
      S_HALT:  o_halted  = 1'b1;
      S_ERR:   o_bus_err = 1'b1;
      default: ;
    endcase
  end

  assign o_state = r_state;

`ifdef SIC4_CTRL_RETIRE_CNT_EN
  logic        w_retire;
  logic [15:0] r_retired;

  assign w_retire = (r_state == S_WB)
                 || ((r_state == S_EXEC) && (i_op == 2'b11))
                 || ((r_state == S_MEM) && i_mem_ack && i_fun_imm[0]);

  // Count completed instructions; wraps naturally at 16 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 16'd1;
  end

  assign o_retired = r_retired;
`endif

endmodule

// File: tb/tb_sic4_ctrl_fsm.sv
// Bench for sic4_ctrl_fsm: per-phase expected-output scoreboard plus literal pins.
module tb_sic4_ctrl_fsm;
  localparam int TO = 15;

  logic clk, rst_n, run, alu_zero, mem_ack;
  logic [1:0] op, rtd, rs, fun_imm;
  logic mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_branch;
  logic [1:0] alu_op;
  logic alu_src, reg_we, wb_sel, halted, bus_err;
  logic [2:0] state;
`ifdef SIC4_CTRL_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  sic4_ctrl_fsm #(.TIMEOUT(TO), .TO_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
    .i_op(op), .i_rtd(rtd), .i_rs(rs), .i_fun_imm(fun_imm),
    .i_alu_zero(alu_zero), .i_mem_ack(mem_ack),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_addr_sel(addr_sel),
    .o_ir_load(ir_load), .o_pc_inc(pc_inc), .o_pc_branch(pc_branch),
    .o_alu_op(alu_op), .o_alu_src(alu_src), .o_reg_we(reg_we),
    .o_wb_sel(wb_sel), .o_halted(halted), .o_bus_err(bus_err),
    .o_state(state)
`ifdef SIC4_CTRL_RETIRE_CNT_EN
    , .o_retired(retired)
`endif
  );

  typedef struct packed {
    logic [2:0] state;
    logic mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_branch;
    logic [1:0] alu_op;
    logic alu_src, reg_we, wb_sel, halted, bus_err;
  } ov_t;

  typedef struct {
    logic rst, run, ack, zero;
    logic [7:0] ir;
    ov_t exp;
    logic [15:0] ret;
  } cyc_t;

  ov_t dut_ov;
  assign dut_ov = {state, mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_branch,
                   alu_op, alu_src, reg_we, wb_sel, halted, bus_err};

  cyc_t q[$];
  logic [7:0]  m_ir;
  logic [15:0] m_ret;
  int checks = 0;
  int errors = 0;

  int cyc_n, n_reg_we, n_memwe, n_ir_load, n_halted, n_branch, n_bus_err, n_wbsel;
  int streak, streak_err, last_ld;
  int gaps[$];
  logic [15:0] ret_at_halt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- model: expected outputs per pipeline phase ----------------
  function automatic logic [2:0] isa(input logic [7:0] ir);
    case (ir[7:6])
      2'b00:   return {ir[1:0], 1'b0};
      2'b01:   return {2'b00, 1'b1};
      2'b10:   return {2'b00, 1'b1};
      default: return {2'b01, 1'b0};
    endcase
  endfunction

  function automatic ov_t ph_fixed(input logic [2:0] st);
    ov_t e;
    e = '0;
    e.state = st;
    e.halted = (st == 3'd6);
    e.bus_err = (st == 3'd7);
    return e;
  endfunction

  function automatic ov_t ph_fetch(input logic ack);
    ov_t e;
    e = '0;
    e.state = 3'd1; e.mem_req = 1'b1; e.ir_load = ack; e.pc_inc = ack;
    return e;
  endfunction

  function automatic ov_t ph_exec(input logic [7:0] ir, input logic zero);
    ov_t e;
    e = '0;
    e.state = 3'd3;
    {e.alu_op, e.alu_src} = isa(ir);
    e.pc_branch = (ir[7:6] == 2'b11) && zero;
    return e;
  endfunction

  function automatic ov_t ph_mem(input logic [7:0] ir);
    ov_t e;
    e = '0;
    e.state = 3'd4; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = ir[0];
    {e.alu_op, e.alu_src} = isa(ir);
    return e;
  endfunction

  function automatic ov_t ph_wb(input logic [7:0] ir);
    ov_t e;
    e = '0;
    e.state = 3'd5; e.reg_we = 1'b1; e.wb_sel = (ir[7:6] == 2'b10);
    {e.alu_op, e.alu_src} = isa(ir);
    return e;
  endfunction

  task automatic push(input ov_t e, input logic rst, input logic rn, input logic ack, input logic zero);
    cyc_t c;
    if (rst) m_ret = '0;
    c.rst = rst; c.run = rn; c.ack = ack; c.zero = zero;
    c.ir = m_ir; c.exp = e; c.ret = m_ret;
    q.push_back(c);
  endtask

  task automatic gen_fetch_wait(input int n);
    for (int i = 0; i < n; i++) push(ph_fetch(1'b0), 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // One instruction: fetch with fwait idle cycles, mwait idle cycles in MEM.
  // noise drives ack=1 and run=0 where both must be ignored.
  task automatic gen_instr(input logic [7:0] ir, input int fwait, input int mwait,
                           input logic zero, input logic noise);
    if (fwait >= TO) begin
      gen_fetch_wait(TO);
      return;
    end
    gen_fetch_wait(fwait);
    push(ph_fetch(1'b1), 1'b0, 1'b1, 1'b1, zero);
    m_ir = ir;
    push(ph_fixed(3'd2), 1'b0, !noise, noise, zero);
    if (ir == 8'hFF) return;
    push(ph_exec(ir, zero), 1'b0, !noise, noise, zero);
    case (ir[7:6])
      2'b00, 2'b01: begin
        push(ph_wb(ir), 1'b0, !noise, noise, zero);
        m_ret = m_ret + 16'd1;
      end
      2'b10: begin
        for (int i = 0; i < mwait; i++) push(ph_mem(ir), 1'b0, !noise, 1'b0, zero);
        push(ph_mem(ir), 1'b0, !noise, 1'b1, zero);
        if (!ir[0]) push(ph_wb(ir), 1'b0, !noise, noise, zero);
        m_ret = m_ret + 16'd1;
      end
      default: m_ret = m_ret + 16'd1;
    endcase
  endtask

  task automatic hold(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) push(ph_fixed(st), 1'b0, (i % 2) == 1, ((i / 2) % 2) == 1, 1'b0);
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic drain();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst_n = !c.rst; run = c.run; mem_ack = c.ack; alu_zero = c.zero;
      {op, rtd, rs, fun_imm} = c.ir;
      #2;
      cyc_n++;
      checks++;
      if (dut_ov !== c.exp) begin
        errors++;
        $display("FAIL cycle %0d outputs: got %h (state %0d) expected %h (state %0d)",
                 cyc_n, dut_ov, state, c.exp, c.exp.state);
      end
`ifdef SIC4_CTRL_RETIRE_CNT_EN
      checks++;
      if (retired !== c.ret) begin
        errors++;
        $display("FAIL cycle %0d retired: got %0d expected %0d", cyc_n, retired, c.ret);
      end
      if (state == 3'd6) ret_at_halt = retired;
`endif
      if (reg_we === 1'b1) n_reg_we++;
      if (mem_we === 1'b1) n_memwe++;
      if (halted === 1'b1) n_halted++;
      if (pc_branch === 1'b1) n_branch++;
      if (bus_err === 1'b1) n_bus_err++;
      if (wb_sel === 1'b1) n_wbsel++;
      if (ir_load === 1'b1) begin
        n_ir_load++;
        if (last_ld >= 0) gaps.push_back(cyc_n - last_ld);
        last_ld = cyc_n;
      end
      if (state == 3'd1) streak++;
      else begin
        if (state == 3'd7 && streak > 0) streak_err = streak;
        streak = 0;
      end
    end
  endtask

  task automatic clear_obs();
    n_reg_we = 0; n_memwe = 0; n_ir_load = 0; n_halted = 0; n_branch = 0;
    n_bus_err = 0; n_wbsel = 0; streak = 0; streak_err = -1; last_ld = -1;
    gaps.delete();
    ret_at_halt = 16'hDEAD;
  endtask

  function automatic int gap_at(input int k);
    return (gaps.size() > k) ? gaps[k] : -1;
  endfunction

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0;
    op = 2'b00; rtd = 2'b00; rs = 2'b00; fun_imm = 2'b00;
    m_ir = 8'h00; m_ret = '0; cyc_n = 0;

    // Scenario A: sub, addi, SW with 3 wait states, HALT.
    clear_obs();
    push(ph_fixed(3'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b0, 1'b1, 1'b0, 1'b0);
    gen_instr(8'h01, 0, 0, 1'b0, 1'b0);
    gen_instr(8'h61, 0, 0, 1'b0, 1'b0);
    gen_instr(8'hA1, 0, 3, 1'b0, 1'b0);
    gen_instr(8'hFF, 0, 0, 1'b0, 1'b0);
    hold(3'd6, 20);
    drain();
    lit("A ir_load pulses", n_ir_load, 4);
    lit("A R-type latency", gap_at(0), 4);
    lit("A ADDI latency", gap_at(1), 4);
    lit("A SW+3wait latency", gap_at(2), 7);
    lit("A reg_we pulses", n_reg_we, 2);
    lit("A mem_we cycles", n_memwe, 4);
    lit("A halted cycles", n_halted, 20);
`ifdef SIC4_CTRL_RETIRE_CNT_EN
    lit("A retired at halt", ret_at_halt, 3);
`endif

    // Scenario B: BEQ taken/not, LW with waits and noise, ack-wins boundary, timeout, resets.
    clear_obs();
    push(ph_fixed(3'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b0, 1'b0, 1'b1, 1'b0);
    push(ph_fixed(3'd0), 1'b0, 1'b1, 1'b0, 1'b0);
    gen_instr(8'hE1, 0, 0, 1'b1, 1'b0);
    gen_instr(8'hE1, 0, 0, 1'b0, 1'b0);
    gen_instr(8'h80, 2, 1, 1'b0, 1'b1);
    gen_instr(8'h01, TO - 1, 0, 1'b0, 1'b0);
    gen_instr(8'h41, TO, 0, 1'b0, 1'b0);
    hold(3'd7, 5);
    push(ph_fixed(3'd0), 1'b1, 1'b1, 1'b1, 1'b0);
    push(ph_fixed(3'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b0, 1'b1, 1'b0, 1'b0);
    gen_fetch_wait(3);
    push(ph_fixed(3'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    push(ph_fixed(3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    lit("B BEQ latency", gap_at(0), 3);
    lit("B pc_branch pulses", n_branch, 1);
    lit("B reg_we pulses", n_reg_we, 2);
    lit("B wb_sel cycles", n_wbsel, 1);
    lit("B FETCH cycles before ERR", streak_err, TO);
    lit("B bus_err cycles", n_bus_err, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
